// File: rtl/shift_unit.sv
// Iterative one-bit-per-cycle shifter/rotator feeding a small result FIFO.
// Requests are accepted only when idle and the FIFO has room, so a push never overflows.
module shift_unit #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [1:0]                    inOp,
  input  logic [MemoryElementWidth-1:0] inValue,
  input  logic [MemoryElementWidth-1:0] inAmount,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [MemoryElementWidth-1:0] outData,
  output logic [$clog2(NOut+1)-1:0]     outCount,
  output logic                          busy
);
  localparam int W = MemoryElementWidth;
  localparam int RemW = $clog2(W + 1);
  localparam int PtrW = $clog2(NOut);
  localparam int CntW = $clog2(NOut + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam logic [1:0] OP_SLL = 2'd0;
  localparam logic [1:0] OP_SRL = 2'd1;
  localparam logic [1:0] OP_SRA = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [1:0]      op_q, op_d;
  logic [RemW-1:0] rem_q, rem_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [W-1:0]    mem_q [NOut];

  logic            accept, push, pop;
  logic [W-1:0]    amt_mod;
  logic [RemW-1:0] rem_init;
  logic [W-1:0]    acc_step;

  assign inReady  = (state_q == IDLE) && (count_q < CntW'(NOut));
  assign accept   = inValid && inReady;
  assign push     = (state_q == WRITE);
  assign pop      = outValid && outReady;
  assign outValid = (count_q != '0);
  assign outCount = count_q;
  assign busy     = (state_q != IDLE);
  assign outData  = outValid ? mem_q[rd_ptr_q] : '0;

  // Rotation only needs the residue; plain shifts saturate at W, which already clears/sign-fills.
  assign amt_mod = inAmount % W'(W);

  always_comb begin
    rem_init = '0;
    if (inOp == 2'd3) begin
      rem_init = amt_mod[RemW-1:0];
    end else if (inAmount >= W'(W)) begin
      rem_init = RemW'(W);
    end else begin
      rem_init = inAmount[RemW-1:0];
    end
  end

  always_comb begin
    case (op_q)
      OP_SLL:  acc_step = {acc_q[W-2:0], 1'b0};
      OP_SRL:  acc_step = {1'b0, acc_q[W-1:1]};
      OP_SRA:  acc_step = {acc_q[W-1], acc_q[W-1:1]};
      default: acc_step = {acc_q[W-2:0], acc_q[W-1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    op_d     = op_q;
    rem_d    = rem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = inValue;
          op_d    = inOp;
          rem_d   = rem_init;
          state_d = (rem_init != '0) ? SHIFT : WRITE;
        end
      end
      SHIFT: begin
        acc_d = acc_step;
        rem_d = rem_q - 1'b1;
        if (rem_q == RemW'(1)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_ptr_d = (wr_ptr_q == PtrW'(NOut - 1)) ? '0 : wr_ptr_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(NOut - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      op_q     <= '0;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left uncleared; the count gates what is visible.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= acc_q;
    end
  end
endmodule
